// File: rtl/piece_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_pkg                                                            |
// | Command codes, FSM states and the piece shape offset table.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package piece_pkg;

    localparam logic [2:0] c_cmd_nop    = 3'd0;
    localparam logic [2:0] c_cmd_left   = 3'd1;
    localparam logic [2:0] c_cmd_right  = 3'd2;
    localparam logic [2:0] c_cmd_rotate = 3'd3;
    localparam logic [2:0] c_cmd_drop   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_EVAL   = 3'd2,
        ST_LOCK   = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    // One shape cell: valid bit, one-row-up offset, one-column-right offset.
    typedef struct packed {
        logic vld;
        logic up;
        logic rt;
    } cell_t;

    typedef cell_t [3:0] shape_t;

    localparam cell_t c_cell_none = 3'b000;
    localparam cell_t c_cell_00   = 3'b100;
    localparam cell_t c_cell_01   = 3'b101;
    localparam cell_t c_cell_10   = 3'b110;
    localparam cell_t c_cell_11   = 3'b111;

    function automatic shape_t shape_lookup(input logic [1:0] typ, input logic [1:0] rot);
        shape_t s;
        s = '0;
        case (typ)
            2'd0: s[0] = c_cell_00;
            2'd1: begin
                s[0] = c_cell_00;
                s[1] = rot[0] ? c_cell_01 : c_cell_10;
            end
            2'd2: s = {c_cell_11, c_cell_10, c_cell_01, c_cell_00};
            default: begin
                case (rot)
                    2'd0:    s = {c_cell_none, c_cell_10, c_cell_01, c_cell_00};
                    2'd1:    s = {c_cell_none, c_cell_11, c_cell_10, c_cell_00};
                    2'd2:    s = {c_cell_none, c_cell_11, c_cell_10, c_cell_01};
                    default: s = {c_cell_none, c_cell_11, c_cell_01, c_cell_00};
                endcase
            end
        endcase
        return s;
    endfunction

    function automatic logic is_move(input logic [2:0] c);
        return (c == c_cmd_left) || (c == c_cmd_right) ||
               (c == c_cmd_rotate) || (c == c_cmd_drop);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_mover_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_mover_if                                                       |
// | Command handshake, board input and piece state outputs.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface piece_mover_if #(
    parameter int COLS = 4,
    parameter int ROWS = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NB = COLS * ROWS;

    logic          spawn;
    logic [1:0]    spawn_type;
    logic          cmd_valid;
    logic [2:0]    cmd;
    logic          cmd_ready;
    logic [NB-1:0] board_in;
    logic [RW-1:0] piece_row;
    logic [CW-1:0] piece_col;
    logic [1:0]    piece_rot;
    logic [1:0]    piece_type;
    logic [NB-1:0] piece_mask;
    logic          active;
    logic          locked;
    logic          rejected;
    logic          game_over;

    modport master (
        output spawn, spawn_type, cmd_valid, cmd, board_in,
        input  cmd_ready, piece_row, piece_col, piece_rot, piece_type,
               piece_mask, active, locked, rejected, game_over
    );

    modport slave (
        input  spawn, spawn_type, cmd_valid, cmd, board_in,
        output cmd_ready, piece_row, piece_col, piece_rot, piece_type,
               piece_mask, active, locked, rejected, game_over
    );
endinterface
`default_nettype wire

// File: rtl/piece_shape.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_shape                                                          |
// | Combinational cell mask and out-of-bounds flag for a placed piece.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module piece_shape
    import piece_pkg::*;
#(
    parameter int COLS = 4,
    parameter int ROWS = 8,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int NB = COLS * ROWS
) (
    input  logic [1:0]    i_type,
    input  logic [1:0]    i_rot,
    input  logic [RW:0]   i_row,
    input  logic [CW:0]   i_col,
    output logic [NB-1:0] o_mask,
    output logic          o_oob
);
    localparam logic [NB-1:0] c_one = {{(NB-1){1'b0}}, 1'b1};

    shape_t        w_shape;
    logic [RW:0]   w_cell_row [4];
    logic [CW+1:0] w_cell_col [4];
    logic [3:0]    w_cell_oob;
    int            w_idx      [4];

    assign w_shape = shape_lookup(i_type, i_rot);

    // Anchor is bottom-left, so an "up" offset moves toward row 0.
    always_comb begin
        o_mask = '0;
        for (int k = 0; k < 4; k++) begin
            w_cell_row[k] = i_row - {{RW{1'b0}}, w_shape[k].up};
            w_cell_col[k] = {1'b0, i_col} + {{(CW+1){1'b0}}, w_shape[k].rt};
            w_cell_oob[k] = w_shape[k].vld &
                            ((i_row < {{RW{1'b0}}, w_shape[k].up}) ||
                             (i_row > (RW+1)'(ROWS-1)) ||
                             (w_cell_col[k] > (CW+2)'(COLS-1)));
            w_idx[k]      = int'(w_cell_row[k]) * COLS + int'(w_cell_col[k]);
            if (w_shape[k].vld && !w_cell_oob[k]) begin
                o_mask = o_mask | (c_one << w_idx[k]);
            end
        end
        o_oob = |w_cell_oob;
    end

endmodule
`default_nettype wire

// File: rtl/piece_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_mover                                                          |
// | Active-piece state machine: spawn, move, rotate, drop and lock.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module piece_mover
    import piece_pkg::*;
#(
    parameter int COLS      = 4,
    parameter int ROWS      = 8,
    parameter int SPAWN_COL = 1
) (
    input  logic         clka,
    input  logic         restart_n,
    piece_mover_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NB = COLS * ROWS;

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [1:0]    r_rot, w_rot_nxt;
    logic [1:0]    r_type, w_type_nxt;
    logic [NB-1:0] r_mask, w_mask_nxt;
    logic          r_active, w_active_nxt;
    logic          r_game_over, w_game_over_nxt;
    logic          r_locked, w_locked_nxt;
    logic          r_rejected, w_rejected_nxt;
    logic          r_cmd_ready, w_cmd_ready_nxt;

    logic [RW:0]   r_cand_row, w_cand_row_nxt;
    logic [CW:0]   r_cand_col, w_cand_col_nxt;
    logic [1:0]    r_cand_rot, w_cand_rot_nxt;
    logic [1:0]    r_cand_type, w_cand_type_nxt;
    logic          r_cand_force, w_cand_force_nxt;
    logic          r_cand_spawn, w_cand_spawn_nxt;
    logic [2:0]    r_cand_cmd, w_cand_cmd_nxt;

    logic [NB-1:0] w_cand_mask;
    logic          w_cand_oob;
    logic          w_blocked;

    piece_shape #(.COLS(COLS), .ROWS(ROWS)) u_cand_shape (
        .i_type (r_cand_type),
        .i_rot  (r_cand_rot),
        .i_row  (r_cand_row),
        .i_col  (r_cand_col),
        .o_mask (w_cand_mask),
        .o_oob  (w_cand_oob)
    );

    // A NOP re-commits the current position, so it can never be blocked.
    assign w_blocked = (r_cand_spawn | is_move(r_cand_cmd)) &
                       (r_cand_force | w_cand_oob | (|(w_cand_mask & bus.board_in)));

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_rot_nxt        = r_rot;
        w_type_nxt       = r_type;
        w_mask_nxt       = r_mask;
        w_active_nxt     = r_active;
        w_game_over_nxt  = r_game_over;
        w_locked_nxt     = 1'b0;
        w_rejected_nxt   = 1'b0;
        w_cand_row_nxt   = r_cand_row;
        w_cand_col_nxt   = r_cand_col;
        w_cand_rot_nxt   = r_cand_rot;
        w_cand_type_nxt  = r_cand_type;
        w_cand_force_nxt = r_cand_force;
        w_cand_spawn_nxt = r_cand_spawn;
        w_cand_cmd_nxt   = r_cand_cmd;

        case (r_state)
            ST_IDLE: begin
                if (bus.spawn) begin
                    w_cand_row_nxt   = (RW+1)'(1);
                    w_cand_col_nxt   = (CW+1)'(SPAWN_COL);
                    w_cand_rot_nxt   = 2'd0;
                    w_cand_type_nxt  = bus.spawn_type;
                    w_cand_force_nxt = 1'b0;
                    w_cand_spawn_nxt = 1'b1;
                    w_cand_cmd_nxt   = c_cmd_nop;
                    w_state_nxt      = ST_EVAL;
                end
            end
            ST_ACTIVE: begin
                if (bus.cmd_valid) begin
                    w_cand_row_nxt   = {1'b0, r_row};
                    w_cand_col_nxt   = {1'b0, r_col};
                    w_cand_rot_nxt   = r_rot;
                    w_cand_type_nxt  = r_type;
                    w_cand_force_nxt = 1'b0;
                    w_cand_spawn_nxt = 1'b0;
                    w_cand_cmd_nxt   = bus.cmd;
                    case (bus.cmd)
                        c_cmd_left: begin
                            w_cand_col_nxt   = {1'b0, r_col} - {{CW{1'b0}}, 1'b1};
                            w_cand_force_nxt = (r_col == '0);
                        end
                        c_cmd_right:  w_cand_col_nxt = {1'b0, r_col} + {{CW{1'b0}}, 1'b1};
                        c_cmd_rotate: w_cand_rot_nxt = r_rot + 2'd1;
                        c_cmd_drop:   w_cand_row_nxt = {1'b0, r_row} + {{RW{1'b0}}, 1'b1};
                        default: ;
                    endcase
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!w_blocked) begin
                    w_row_nxt    = r_cand_row[RW-1:0];
                    w_col_nxt    = r_cand_col[CW-1:0];
                    w_rot_nxt    = r_cand_rot;
                    w_type_nxt   = r_cand_type;
                    w_mask_nxt   = w_cand_mask;
                    w_active_nxt = 1'b1;
                    w_state_nxt  = ST_ACTIVE;
                end else if (r_cand_spawn) begin
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = ST_OVER;
                end else if (r_cand_cmd == c_cmd_drop) begin
                    w_locked_nxt = 1'b1;
                    w_state_nxt  = ST_LOCK;
                end else begin
                    w_rejected_nxt = 1'b1;
                    w_state_nxt    = ST_ACTIVE;
                end
            end
            ST_LOCK: begin
                w_active_nxt = 1'b0;
                w_mask_nxt   = '0;
                w_state_nxt  = ST_IDLE;
            end
            ST_OVER: ;
            default: w_state_nxt = ST_IDLE;
        endcase

        w_cmd_ready_nxt = (w_state_nxt == ST_ACTIVE);
    end

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_rot        <= '0;
            r_type       <= '0;
            r_mask       <= '0;
            r_active     <= 1'b0;
            r_game_over  <= 1'b0;
            r_locked     <= 1'b0;
            r_rejected   <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_cand_row   <= '0;
            r_cand_col   <= '0;
            r_cand_rot   <= '0;
            r_cand_type  <= '0;
            r_cand_force <= 1'b0;
            r_cand_spawn <= 1'b0;
            r_cand_cmd   <= c_cmd_nop;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_rot        <= w_rot_nxt;
            r_type       <= w_type_nxt;
            r_mask       <= w_mask_nxt;
            r_active     <= w_active_nxt;
            r_game_over  <= w_game_over_nxt;
            r_locked     <= w_locked_nxt;
            r_rejected   <= w_rejected_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_cand_row   <= w_cand_row_nxt;
            r_cand_col   <= w_cand_col_nxt;
            r_cand_rot   <= w_cand_rot_nxt;
            r_cand_type  <= w_cand_type_nxt;
            r_cand_force <= w_cand_force_nxt;
            r_cand_spawn <= w_cand_spawn_nxt;
            r_cand_cmd   <= w_cand_cmd_nxt;
        end
    end

    assign bus.piece_row  = r_row;
    assign bus.piece_col  = r_col;
    assign bus.piece_rot  = r_rot;
    assign bus.piece_type = r_type;
    assign bus.piece_mask = r_mask;
    assign bus.active     = r_active;
    assign bus.locked     = r_locked;
    assign bus.rejected   = r_rejected;
    assign bus.game_over  = r_game_over;
    assign bus.cmd_ready  = r_cmd_ready;

endmodule
`default_nettype wire

// File: tb/tb_piece_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piece_mover                                                       |
// | Directed and randomized bench with a cell-level reference model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_piece_mover;
    localparam int COLS      = 4;
    localparam int ROWS      = 8;
    localparam int NB        = COLS * ROWS;
    localparam int SPAWN_COL = 1;

    logic clk       = 1'b0;
    logic restart_n = 1'b0;
    always #5 clk = ~clk;

    piece_mover_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    piece_mover #(.COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL)) dut (
        .clka      (clk),
        .restart_n (restart_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: piece as plain integers plus expected pulses.
    int m_row, m_col, m_rot, m_type;
    bit m_active, m_over, e_ready, e_locked, e_rejected;
    logic [NB-1:0] board, exp_mask, g_lockmask, s_mask;
    bit g_lock, s_locked, s_rejected, cmp_oob;

    assign bus.board_in = board;

    // Cells of a shape as offset codes up*2+right, placed with signed arithmetic.
    function automatic logic [NB-1:0] place(input int t, input int r, input int row,
                                            input int col, output bit oob);
        int offs[4];
        int n;
        int rr;
        int cc;
        logic [NB-1:0] m;
        offs = '{0, 0, 0, 0};
        n = 0;
        case (t)
            0: begin offs = '{0, 0, 0, 0}; n = 1; end
            1: begin offs = (r % 2 == 0) ? '{0, 2, 0, 0} : '{0, 1, 0, 0}; n = 2; end
            2: begin offs = '{0, 1, 2, 3}; n = 4; end
            default: begin
                n = 3;
                case (r)
                    0: offs = '{0, 1, 2, 0};
                    1: offs = '{0, 2, 3, 0};
                    2: offs = '{1, 2, 3, 0};
                    default: offs = '{0, 1, 3, 0};
                endcase
            end
        endcase
        m = '0;
        oob = 1'b0;
        for (int k = 0; k < n; k++) begin
            rr = row - offs[k] / 2;
            cc = col + offs[k] % 2;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) oob = 1'b1;
            else m = m | (NB'(1) << (rr * COLS + cc));
        end
        return m;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_active) exp_mask = place(m_type, m_rot, m_row, m_col, cmp_oob);
            else          exp_mask = '0;
            cmp("piece_row",  bus.piece_row,  m_row);
            cmp("piece_col",  bus.piece_col,  m_col);
            cmp("piece_rot",  bus.piece_rot,  m_rot);
            cmp("piece_type", bus.piece_type, m_type);
            cmp("piece_mask", bus.piece_mask, exp_mask);
            cmp("active",     bus.active,     m_active);
            cmp("game_over",  bus.game_over,  m_over);
            cmp("cmd_ready",  bus.cmd_ready,  e_ready);
            cmp("locked",     bus.locked,     e_locked);
            cmp("rejected",   bus.rejected,   e_rejected);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_rot = 0; m_type = 0;
        m_active = 0; m_over = 0;
        e_ready = 0; e_locked = 0; e_rejected = 0;
    endtask

    task automatic reset_dut();
        restart_n = 1'b0;
        tick();
        model_reset();
        restart_n = 1'b1;
    endtask

    task automatic do_spawn(input int t);
        bit idle;
        bit blk;
        logic [NB-1:0] m;
        idle = !m_active && !m_over;
        bus.spawn      = 1'b1;
        bus.spawn_type = 2'(t);
        bus.cmd_valid  = 1'($urandom_range(0, 1));
        bus.cmd        = 3'($urandom_range(0, 7));
        tick();
        bus.spawn     = 1'b0;
        bus.cmd_valid = 1'b0;
        tick();
        if (idle) begin
            m = place(t, 0, 1, SPAWN_COL, blk);
            if (blk || (m & board) != '0) begin
                m_over = 1'b1;
            end else begin
                m_active = 1'b1; m_row = 1; m_col = SPAWN_COL; m_rot = 0; m_type = t;
                e_ready = 1'b1;
            end
        end
    endtask

    task automatic do_cmd(input int c, input bit abort);
        int nr, nc, nrot;
        bit blk;
        logic [NB-1:0] m;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 3'(c);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'($urandom_range(0, 7));
        bus.spawn     = 1'($urandom_range(0, 1));
        e_ready = 1'b0;
        if (abort) restart_n = 1'b0;
        tick();
        bus.spawn = 1'b0;
        if (abort) begin
            model_reset();
            restart_n  = 1'b1;
            s_locked   = bus.locked;
            s_rejected = bus.rejected;
            s_mask     = bus.piece_mask;
            return;
        end
        nr = m_row; nc = m_col; nrot = m_rot;
        case (c)
            1: nc = nc - 1;
            2: nc = nc + 1;
            3: nrot = (nrot + 1) % 4;
            4: nr = nr + 1;
            default: ;
        endcase
        if (c < 1 || c > 4) begin
            e_ready = 1'b1;
        end else begin
            m = place(m_type, nrot, nr, nc, blk);
            if (!blk && (m & board) == '0) begin
                m_row = nr; m_col = nc; m_rot = nrot;
                e_ready = 1'b1;
            end else if (c == 4) begin
                e_locked = 1'b1;
            end else begin
                e_rejected = 1'b1;
                e_ready = 1'b1;
            end
        end
        s_locked   = bus.locked;
        s_rejected = bus.rejected;
        s_mask     = bus.piece_mask;
        tick();
        e_rejected = 1'b0;
        if (e_locked) begin
            g_lockmask = place(m_type, m_rot, m_row, m_col, blk);
            g_lock     = 1'b1;
            e_locked   = 1'b0;
            m_active   = 1'b0;
        end
    endtask

    task automatic drop_to_lock();
        for (int i = 0; i < ROWS + 2; i++) begin
            do_cmd(4, 1'b0);
            if (s_locked) break;
        end
        cmp("drop_to_lock", s_locked, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.spawn = 1'b0; bus.spawn_type = 2'd0; bus.cmd_valid = 1'b0; bus.cmd = 3'd0;
        board = '0; g_lock = 1'b0;
        model_reset();
        restart_n = 1'b0;
        tick(); tick();
        restart_n = 1'b1;
        chk_en = 1'b1;
        cmp("reset_ready",  bus.cmd_ready, 0);
        cmp("reset_active", bus.active, 0);
        cmp("reset_over",   bus.game_over, 0);
        cmp("reset_mask",   bus.piece_mask, 0);

        // Square spawn on an empty board
        do_spawn(2);
        cmp("sq_active", bus.active, 1);
        cmp("sq_row",    bus.piece_row, 1);
        cmp("sq_col",    bus.piece_col, 1);
        cmp("sq_mask",   bus.piece_mask, 32'h66);
        drop_to_lock();

        // Side walls with a single cell
        do_spawn(0);
        do_cmd(1, 1'b0);
        cmp("left_col0", bus.piece_col, 0);
        do_cmd(1, 1'b0);
        cmp("left_wall_rej", s_rejected, 1);
        cmp("left_wall_col", bus.piece_col, 0);
        for (int i = 0; i < 3; i++) do_cmd(2, 1'b0);
        cmp("right_col3", bus.piece_col, 3);
        do_cmd(2, 1'b0);
        cmp("right_wall_rej", s_rejected, 1);
        drop_to_lock();

        // Rotation against the right wall
        do_spawn(1);
        do_cmd(2, 1'b0);
        do_cmd(2, 1'b0);
        do_cmd(3, 1'b0);
        cmp("rot_wall_rej", s_rejected, 1);
        cmp("rot_wall_rot", bus.piece_rot, 0);
        do_cmd(1, 1'b0);
        do_cmd(3, 1'b0);
        cmp("rot_ok_rot",  bus.piece_rot, 1);
        cmp("rot_ok_mask", bus.piece_mask, 32'hC0);
        drop_to_lock();

        // Floor landing
        do_spawn(0);
        for (int i = 0; i < 6; i++) do_cmd(4, 1'b0);
        cmp("floor_row", bus.piece_row, 7);
        do_cmd(4, 1'b0);
        cmp("floor_locked", s_locked, 1);
        cmp("floor_mask",   s_mask, 32'h2000_0000);
        cmp("floor_idle",   bus.active, 0);

        // Landing on a locked cell, then reset mid-evaluation
        board = 32'h200;
        do_spawn(0);
        do_cmd(4, 1'b0);
        cmp("stack_locked", s_locked, 1);
        cmp("stack_mask",   s_mask, 32'h20);
        board = '0;
        do_spawn(0);
        do_cmd(4, 1'b1);
        cmp("abort_mask",   bus.piece_mask, 0);
        cmp("abort_active", bus.active, 0);
        cmp("abort_locked", s_locked, 0);
        cmp("abort_rej",    s_rejected, 0);

        // Blocked spawn
        board = 32'h20;
        do_spawn(0);
        cmp("over_set", bus.game_over, 1);
        do_spawn(1);
        cmp("over_sticky", bus.game_over, 1);
        cmp("over_active", bus.active, 0);
        reset_dut();
        cmp("over_clear", bus.game_over, 0);
        board = '0;

        // Randomized play with locks merged into the board
        for (int it = 0; it < 400; it++) begin
            if (m_over) begin
                reset_dut();
                board = NB'($urandom & $urandom) & 32'hFFFF_0000;
            end else if (!m_active) begin
                if (g_lock) begin
                    board  = board | g_lockmask;
                    g_lock = 1'b0;
                end
                do_spawn($urandom_range(0, 3));
            end else begin
                c = $urandom_range(0, 11);
                if (c > 7) c = 4;
                do_cmd(c, ($urandom_range(0, 49) == 0));
                g_lock = g_lock && !m_over;
            end
        end

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_mover.md
# piece_mover

Parametrised successor to the per-frame piece update logic, on a single clock. It holds the active falling piece as row, column, rotation and type, and accepts left, right, rotate and drop commands through a valid/ready handshake. Each candidate position is checked against the locked-cell board and the board edges before it is committed. It sits between the input/timer controller, which issues the commands, and the board register, which merges `lock_mask` when a piece lands.

## Interface
- `COLS`, default 4: board width in cells.
- `ROWS`, default 8: board height in cells. Row 0 is the top row.
- `SPAWN_COL`, default 1: anchor column used at spawn. Spawn row is fixed at 1.
- Derived widths: `RW = $clog2(ROWS)`, `CW = $clog2(COLS)`, `NB = COLS*ROWS`.
- Cell index: `row*COLS + col`.

Ports:
- `clka` in 1: sole clock, rising edge.
- `restart_n` in 1: reset, synchronous, active-low.
- `spawn` in 1: request a new piece. Honoured only in IDLE.
- `spawn_type` in 2: piece type for the spawn.
- `cmd_valid` in 1: command valid.
- `cmd` in 3: command code. 1=LEFT, 2=RIGHT, 3=ROTATE, 4=DROP. All other codes are NOP.
- `cmd_ready` out 1: command accept.
- `board_in` in NB: locked cells. Must exclude the active piece.
- `piece_row` out RW, `piece_col` out CW: anchor position, the bottom-left of the bounding box.
- `piece_rot` out 2, `piece_type` out 2: current rotation and type.
- `piece_mask` out NB: cells occupied by the active piece.
- `active` out 1: a piece is in play.
- `locked` out 1: one-cycle pulse. `piece_mask` is valid as the lock mask in that cycle.
- `rejected` out 1: one-cycle pulse when a LEFT, RIGHT or ROTATE command is blocked.
- `game_over` out 1: sticky until reset.

## Operation
Shapes are given as (up, right) offsets from the anchor:
- Type 0: (0,0).
- Type 1, rot 0/2: (0,0),(1,0). Rot 1/3: (0,0),(0,1).
- Type 2, all rotations: (0,0),(0,1),(1,0),(1,1).
- Type 3, rot 0: (0,0),(0,1),(1,0). Rot 1: (0,0),(1,0),(1,1). Rot 2: (0,1),(1,0),(1,1). Rot 3: (0,0),(0,1),(1,1).

Collision rule:
- A candidate is blocked if any cell satisfies `row-up < 0`, `row > ROWS-1`, `col+right > COLS-1`, or lies on a set `board_in` bit.
- Edge tests use (CW+1)/(RW+1)-bit arithmetic. There is no wrap-around.

Candidate derived from each command:
- LEFT: col-1. At col 0 the candidate is blocked.
- RIGHT: col+1.
- ROTATE: (rot+1) mod 4, same anchor, no wall kicks.
- DROP: row+1.
- NOP: unchanged.

State machine:
- IDLE: `cmd_ready`=0.
  - `spawn`=1 → candidate = (1, SPAWN_COL, rot 0, `spawn_type`), go to EVAL.
  - Commands are not accepted.
- ACTIVE: `cmd_ready`=1.
  - `cmd_valid`=1 → latch command and candidate, go to EVAL.
- EVAL: `cmd_ready`=0. `board_in` is sampled in this cycle and must be stable.
  - Free → commit candidate, go to ACTIVE. A spawn also sets `active`.
  - Blocked spawn → OVER.
  - Blocked DROP → LOCK, position unchanged.
  - Blocked LEFT/RIGHT/ROTATE → pulse `rejected`, go to ACTIVE, position unchanged.
  - NOP is never blocked.
- LOCK: `locked`=1 for one cycle with `piece_mask` unchanged, then IDLE.
  - On entry to IDLE, `active` and `piece_mask` are cleared.
- OVER: `game_over`=1. `spawn` and commands are ignored. Only reset exits.

`spawn` is ignored outside IDLE. `spawn` and `cmd_valid` can only coincide in IDLE, where `cmd_valid` is ignored.

Reset:
- `restart_n`=0 at any edge, including mid-EVAL or in LOCK → next state IDLE.
- All outputs are 0: position/rot/type, `piece_mask`, `active`, `locked`, `rejected`, `game_over`, `cmd_ready`.
- An in-flight command is dropped with no pulse.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- A command is accepted at edge N, when `cmd_valid` & `cmd_ready`. EVAL occupies cycle N+1.
- The new position, or a `rejected` pulse, is visible in cycle N+2. `cmd_ready` returns high in N+2.
- Throughput is one command per 2 cycles.
- Spawn sampled at edge N: `active`/`piece_mask` are valid in N+2, or `game_over` in N+2.
- DROP blocked: `locked` is high in N+2 only. IDLE is entered at N+3.
- A DROP that lands and a blocked move are never reported as `rejected` together.

## Structure
- Package `piece_pkg`: command codes, state enum, and the shape offset table (type × rot → 4 offsets + cell-valid bits).
- Sub-module `piece_shape`: combinational. Inputs type, rot, row, col, `COLS`/`ROWS`. Outputs NB-bit mask and `oob` flag.
  - Two instances are natural: one for the candidate, one for the committed mask. Alternatively, register the candidate mask on commit.
- Estimated 200–300 lines.

## Test plan
All scenarios use COLS=4, ROWS=8.
- Reset, then spawn type 2 on an empty board → cycle N+2: `active`=1, row 1, col 1, `piece_mask`=0x66.
- Type 0 at col 0, LEFT → `rejected` pulse, col 0. Then RIGHT ×3 → col 3. A fourth RIGHT → `rejected`.
- Type 1 rot 0 at col 3, ROTATE → `rejected`, rot 0. Move to col 2, ROTATE → rot 1, mask bits {6,7}.
- Type 0 spawned on an empty board, DROP repeated → row 7 after 6 drops. Seventh DROP → `locked` for one cycle with mask bit 29, then `active`=0.
- `board_in` bit 9 set, type 0 at (1,1), DROP → `locked`, lock mask bit 5. Separately, `restart_n`=0 during EVAL → all outputs 0 next cycle, no pulse.
- `board_in` bit 5 set, spawn type 0 → `game_over`=1. A further `spawn` is ignored. `restart_n` low for one cycle clears `game_over`.
